// File: rtl/imager_tx_pkg.sv
// imager_tx_pkg: shared stream type codes and transmit-side state encoding
// for the imaging pipeline.
//   DTYPE_*     : codes carried on the typed pixel stream (dtype bus)
//   tx_state_e  : imager_tx framing states
//   sat_inc8    : 8-bit saturating increment, used by the header word counter
package imager_tx_pkg;

  localparam int DTYPE_WIDTH = 4;
  typedef logic [DTYPE_WIDTH-1:0] dtype_t;

  localparam dtype_t DTYPE_PIXEL        = 4'h0;
  localparam dtype_t DTYPE_FRAME_START  = 4'h1;
  localparam dtype_t DTYPE_FRAME_END    = 4'h2;
  localparam dtype_t DTYPE_ROW_START    = 4'h3;
  localparam dtype_t DTYPE_ROW_END      = 4'h4;
  localparam dtype_t DTYPE_HEADER_START = 4'h5;
  localparam dtype_t DTYPE_HEADER       = 4'h6;
  localparam dtype_t DTYPE_HEADER_END   = 4'h7;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_FRAME  = 2'd1,
    TX_ROW    = 2'd2,
    TX_HEADER = 2'd3
  } tx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/imager_tx.sv
// imager_tx: rebuilds sensor-style fv/lv/dv/data timing from the typed pixel
// stream. Header packets are counted and stripped; frame/row geometry is
// measured. All outputs are registered, one cycle after the input word.
// Ports:
//   clk, resetb          clock, async active-low reset
//   enable               block enable; dropping it mid-frame aborts the frame
//   left_justify         pixel taken from MSBs (1) or LSBs (0) of datai
//   clear_errors         clears sticky error flags (a same-cycle set wins)
//   dvi, dtypei, datai   input stream
//   fv, lv, dvo, datao   regenerated video timing / pixel
//   num_rows, num_cols   geometry of the last completed frame / row
//   frame_count          datai[15:0] of the last FRAME_START
//   header_words         HEADER words in the last header packet
//   err_proto, err_abort sticky error flags
module imager_tx
  import imager_tx_pkg::*;
#(
  parameter int PIXEL_WIDTH = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   left_justify,
  input  logic                   clear_errors,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]  datai,
  output logic                   fv,
  output logic                   lv,
  output logic                   dvo,
  output logic [PIXEL_WIDTH-1:0] datao,
  output logic [DIM_WIDTH-1:0]   num_rows,
  output logic [DIM_WIDTH-1:0]   num_cols,
  output logic [15:0]            frame_count,
  output logic [7:0]             header_words,
  output logic                   err_proto,
  output logic                   err_abort
);

  tx_state_e              state_q, state_d;
  logic                   fv_q, fv_d, lv_q, lv_d, dvo_q, dvo_d;
  logic [PIXEL_WIDTH-1:0] datao_q, datao_d;
  logic [DIM_WIDTH-1:0]   row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
  logic [DIM_WIDTH-1:0]   num_rows_q, num_rows_d, num_cols_q, num_cols_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [7:0]             hdr_cnt_q, hdr_cnt_d, header_words_q, header_words_d;
  logic                   err_proto_q, err_proto_d, err_abort_q, err_abort_d;
  // Set after enable drops: stream is discarded silently until a FRAME_START.
  logic                   resync_q, resync_d;

  logic                   proto_set, abort_set, start_frame;
  logic [PIXEL_WIDTH-1:0] pixel;
  logic [DATA_WIDTH+15:0] datai_ext;

  assign pixel     = left_justify ? datai[DATA_WIDTH-1 -: PIXEL_WIDTH]
                                  : datai[PIXEL_WIDTH-1:0];
  // Zero-extend so frame_count capture is legal for any DATA_WIDTH.
  assign datai_ext = {16'b0, datai};

  always_comb begin
    state_d        = state_q;
    fv_d           = fv_q;
    lv_d           = lv_q;
    dvo_d          = 1'b0;
    datao_d        = '0;
    row_cnt_d      = row_cnt_q;
    col_cnt_d      = col_cnt_q;
    num_rows_d     = num_rows_q;
    num_cols_d     = num_cols_q;
    frame_count_d  = frame_count_q;
    hdr_cnt_d      = hdr_cnt_q;
    header_words_d = header_words_q;
    resync_d       = resync_q;
    proto_set      = 1'b0;
    abort_set      = 1'b0;
    start_frame    = 1'b0;

    if (!enable) begin
      state_d  = TX_IDLE;
      fv_d     = 1'b0;
      lv_d     = 1'b0;
      resync_d = 1'b1;
      abort_set = (state_q == TX_FRAME) || (state_q == TX_ROW);
    end else if (dvi) begin
      unique case (state_q)
        TX_IDLE: begin
          if (dtypei == DTYPE_FRAME_START) begin
            start_frame = 1'b1;
          end else if (!resync_q) begin
            if (dtypei == DTYPE_HEADER_START) begin
              hdr_cnt_d = '0;
              state_d   = TX_HEADER;
            end else begin
              proto_set = 1'b1;
            end
          end
        end
        TX_FRAME: begin
          unique case (dtypei)
            DTYPE_ROW_START: begin
              lv_d      = 1'b1;
              col_cnt_d = '0;
              state_d   = TX_ROW;
            end
            DTYPE_FRAME_END: begin
              fv_d       = 1'b0;
              num_rows_d = row_cnt_q;
              state_d    = TX_IDLE;
            end
            DTYPE_FRAME_START: begin
              proto_set   = 1'b1;
              start_frame = 1'b1;
            end
            default: proto_set = 1'b1;
          endcase
        end
        TX_ROW: begin
          unique case (dtypei)
            DTYPE_PIXEL: begin
              dvo_d     = 1'b1;
              datao_d   = pixel;
              col_cnt_d = col_cnt_q + 1'b1;
            end
            DTYPE_ROW_END: begin
              lv_d       = 1'b0;
              num_cols_d = col_cnt_q;
              row_cnt_d  = row_cnt_q + 1'b1;
              state_d    = TX_FRAME;
            end
            DTYPE_FRAME_END: begin
              // Implicit row end: lv and fv fall together.
              lv_d       = 1'b0;
              fv_d       = 1'b0;
              num_cols_d = col_cnt_q;
              num_rows_d = row_cnt_q + 1'b1;
              state_d    = TX_IDLE;
            end
            DTYPE_ROW_START: begin
              proto_set = 1'b1;
              col_cnt_d = '0;
            end
            DTYPE_FRAME_START: begin
              proto_set   = 1'b1;
              start_frame = 1'b1;
            end
            default: proto_set = 1'b1;
          endcase
        end
        TX_HEADER: begin
          unique case (dtypei)
            DTYPE_HEADER:     hdr_cnt_d = sat_inc8(hdr_cnt_q);
            DTYPE_HEADER_END: begin
              header_words_d = hdr_cnt_q;
              state_d        = TX_IDLE;
            end
            DTYPE_FRAME_START: begin
              proto_set      = 1'b1;
              header_words_d = hdr_cnt_q;
              start_frame    = 1'b1;
            end
            default: proto_set = 1'b1;
          endcase
        end
        default: state_d = TX_IDLE;
      endcase

      if (start_frame) begin
        fv_d          = 1'b1;
        lv_d          = 1'b0;
        frame_count_d = datai_ext[15:0];
        row_cnt_d     = '0;
        resync_d      = 1'b0;
        state_d       = TX_FRAME;
      end
    end

    err_proto_d = (err_proto_q & ~clear_errors) | proto_set;
    err_abort_d = (err_abort_q & ~clear_errors) | abort_set;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= TX_IDLE;
      fv_q           <= 1'b0;
      lv_q           <= 1'b0;
      dvo_q          <= 1'b0;
      datao_q        <= '0;
      row_cnt_q      <= '0;
      col_cnt_q      <= '0;
      num_rows_q     <= '0;
      num_cols_q     <= '0;
      frame_count_q  <= '0;
      hdr_cnt_q      <= '0;
      header_words_q <= '0;
      err_proto_q    <= 1'b0;
      err_abort_q    <= 1'b0;
      resync_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      fv_q           <= fv_d;
      lv_q           <= lv_d;
      dvo_q          <= dvo_d;
      datao_q        <= datao_d;
      row_cnt_q      <= row_cnt_d;
      col_cnt_q      <= col_cnt_d;
      num_rows_q     <= num_rows_d;
      num_cols_q     <= num_cols_d;
      frame_count_q  <= frame_count_d;
      hdr_cnt_q      <= hdr_cnt_d;
      header_words_q <= header_words_d;
      err_proto_q    <= err_proto_d;
      err_abort_q    <= err_abort_d;
      resync_q       <= resync_d;
    end
  end

  assign fv           = fv_q;
  assign lv           = lv_q;
  assign dvo          = dvo_q;
  assign datao        = datao_q;
  assign num_rows     = num_rows_q;
  assign num_cols     = num_cols_q;
  assign frame_count  = frame_count_q;
  assign header_words = header_words_q;
  assign err_proto    = err_proto_q;
  assign err_abort    = err_abort_q;

endmodule

// File: tb/tb_imager_tx.sv
module tb_imager_tx;
  import imager_tx_pkg::*;

  localparam int PW = 12;
  localparam int DW = 16;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          resetb, enable, left_justify, clear_errors, dvi;
  logic [DTYPE_WIDTH-1:0] dtypei;
  logic [DW-1:0] datai;
  logic          fv, lv, dvo;
  logic [PW-1:0] datao;
  logic [NW-1:0] num_rows, num_cols;
  logic [15:0]   frame_count;
  logic [7:0]    header_words;
  logic          err_proto, err_abort;

  imager_tx #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .DIM_WIDTH(NW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .left_justify(left_justify),
    .clear_errors(clear_errors), .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .fv(fv), .lv(lv), .dvo(dvo), .datao(datao), .num_rows(num_rows),
    .num_cols(num_cols), .frame_count(frame_count), .header_words(header_words),
    .err_proto(err_proto), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          fv;
    logic          lv;
    logic          dvo;
    logic [PW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one word, push its expected video output, then pop and compare
  // after the edge that registers it.
  task automatic send(input logic v, input dtype_t t, input logic [DW-1:0] d,
                      input logic efv, input logic elv, input logic edvo,
                      input logic [PW-1:0] ed);
    exp_t e, got;
    dvi = v; dtypei = t; datai = d;
    exp_q.push_back('{fv: efv, lv: elv, dvo: edvo, d: ed});
    @(posedge clk); #1;
    e   = exp_q.pop_front();
    got = '{fv: fv, lv: lv, dvo: dvo, d: datao};
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL word t=%0h d=%h got fv/lv/dvo/data=%b%b%b/%h exp=%b%b%b/%h",
             t, d, got.fv, got.lv, got.dvo, got.d, e.fv, e.lv, e.dvo, e.d);
    end
    dvi = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] e);
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, e);
    end
  endtask

  initial begin
    logic [PW-1:0] p;
    resetb = 1'b0; enable = 1'b1; left_justify = 1'b1; clear_errors = 1'b0;
    dvi = 1'b0; dtypei = DTYPE_PIXEL; datai = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {fv, lv, dvo, datao, num_rows[3:0], num_cols[3:0], frame_count[3:0],
                  header_words[3:0], err_proto, err_abort}, 32'h0);
    resetb = 1'b1;
    @(posedge clk); #1;

    // Frame 1: 3 rows x 4 pixels, left justified.
    send(1, DTYPE_FRAME_START, 16'd7, 1, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      send(1, DTYPE_ROW_START, 0, 1, 1, 0, 0);
      for (int c = 0; c < 4; c++) begin
        p = 12'hABC + 12'(r * 4 + c);
        send(1, DTYPE_PIXEL, {p, 4'h0}, 1, 1, 1, p);
      end
      send(1, DTYPE_ROW_END, 0, 1, 0, 0, 0);
    end
    send(1, DTYPE_FRAME_END, 0, 0, 0, 0, 0);
    chk("num_rows1", 32'(num_rows), 32'd3);
    chk("num_cols1", 32'(num_cols), 32'd4);
    chk("frame_count1", 32'(frame_count), 32'd7);
    chk("errs1", {30'b0, err_proto, err_abort}, 32'd0);

    // Frame 2: right justified, bubble inside a row, last row closed by FRAME_END.
    left_justify = 1'b0;
    send(1, DTYPE_FRAME_START, 16'd9, 1, 0, 0, 0);
    send(1, DTYPE_ROW_START, 0, 1, 1, 0, 0);
    send(1, DTYPE_PIXEL, 16'h0ABC, 1, 1, 1, 12'hABC);
    send(0, DTYPE_PIXEL, 16'hFFFF, 1, 1, 0, 0);
    send(1, DTYPE_PIXEL, 16'hF123, 1, 1, 1, 12'h123);
    send(1, DTYPE_ROW_END, 0, 1, 0, 0, 0);
    send(1, DTYPE_ROW_START, 0, 1, 1, 0, 0);
    send(1, DTYPE_PIXEL, 16'h0001, 1, 1, 1, 12'h001);
    send(1, DTYPE_PIXEL, 16'h0FFF, 1, 1, 1, 12'hFFF);
    send(1, DTYPE_PIXEL, 16'h0555, 1, 1, 1, 12'h555);
    send(1, DTYPE_FRAME_END, 0, 0, 0, 0, 0);
    chk("num_rows2", 32'(num_rows), 32'd2);
    chk("num_cols2", 32'(num_cols), 32'd3);
    chk("frame_count2", 32'(frame_count), 32'd9);

    // Header packet: stripped, counted.
    send(1, DTYPE_HEADER_START, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) send(1, DTYPE_HEADER, 16'(i), 0, 0, 0, 0);
    send(1, DTYPE_HEADER_END, 0, 0, 0, 0, 0);
    chk("header_words", 32'(header_words), 32'd32);
    chk("errs_hdr", {30'b0, err_proto, err_abort}, 32'd0);

    // Abort mid-row via enable.
    send(1, DTYPE_FRAME_START, 16'd1, 1, 0, 0, 0);
    send(1, DTYPE_ROW_START, 0, 1, 1, 0, 0);
    send(1, DTYPE_PIXEL, 16'h0042, 1, 1, 1, 12'h042);
    enable = 1'b0;
    send(0, DTYPE_PIXEL, 0, 0, 0, 0, 0);
    chk("err_abort_set", 32'(err_abort), 32'd1);
    chk("geom_kept", {num_rows, num_cols}, {16'd2, 16'd3});
    send(1, DTYPE_PIXEL, 16'h0777, 0, 0, 0, 0);
    enable = 1'b1;
    send(1, DTYPE_ROW_START, 0, 0, 0, 0, 0);
    send(1, DTYPE_PIXEL, 16'h0333, 0, 0, 0, 0);
    send(1, DTYPE_ROW_END, 0, 0, 0, 0, 0);
    send(1, DTYPE_FRAME_END, 0, 0, 0, 0, 0);
    chk("no_proto_resync", 32'(err_proto), 32'd0);
    clear_errors = 1'b1;
    send(0, DTYPE_PIXEL, 0, 0, 0, 0, 0);
    clear_errors = 1'b0;
    chk("err_abort_clr", 32'(err_abort), 32'd0);

    // Protocol error: PIXEL directly in FRAME.
    send(1, DTYPE_FRAME_START, 16'd5, 1, 0, 0, 0);
    send(1, DTYPE_PIXEL, 16'h0AAA, 1, 0, 0, 0);
    chk("err_proto_set", 32'(err_proto), 32'd1);
    send(1, DTYPE_FRAME_END, 0, 0, 0, 0, 0);
    chk("num_rows0", 32'(num_rows), 32'd0);
    chk("frame_count5", 32'(frame_count), 32'd5);
    // Set and clear in the same cycle: set wins.
    clear_errors = 1'b1;
    send(1, DTYPE_PIXEL, 16'h0001, 0, 0, 0, 0);
    chk("set_wins", 32'(err_proto), 32'd1);
    send(0, DTYPE_PIXEL, 0, 0, 0, 0, 0);
    clear_errors = 1'b0;
    chk("err_proto_clr", 32'(err_proto), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
